// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding, default operand width and counter-width helper
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int WIDTH_DEF = 3;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
  localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);
endpackage

// File: rtl/ripple_adder.sv
// ripple_adder: WIDTH-bit ripple-carry adder (a, b -> s, co) from one half_adder and WIDTH-1 full_adders
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  logic [WIDTH:1] c;
  half_adder u_ha (.a(a[0]), .b(b[0]), .s(s[0]), .c(c[1]));
  for (genvar i = 1; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co = c[WIDTH];
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: shift-and-add multiplier FSM (clk, rst, start, A, B -> ready, busy, done, P); SEQ_MULT_ZERO_BYPASS_EN skips zero operands
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = cnt_w(WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplr_q, mplr_d, acc_q, acc_d, addend, sum;
  logic [2*WIDTH-1:0] p_q, p_d, shifted;
  logic               carry;
  assign addend  = mplr_q[0] ? mcand_q : '0;
  ripple_adder #(.WIDTH(WIDTH)) u_add (.a(acc_q), .b(addend), .s(sum), .co(carry));
  assign shifted = {carry, sum, mplr_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d = A;
        mplr_d  = B;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
        if (A == '0 || B == '0) begin
          state_d = DONE;
          p_d     = '0;
        end
`endif
      end
      RUN: begin
        {acc_d, mplr_d} = shifted;
        cnt_d           = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          p_d     = shifted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy  = state_q == RUN;
  assign done  = state_q == DONE;
  assign P     = p_q;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: scoreboard bench for the WIDTH=3 sequential multiplier
module tb_seq_mult_ctrl;
  logic       clk = 0, rst = 1, start = 0;
  logic [2:0] A = 0, B = 0;
  logic       ready, busy, done;
  logic [5:0] P;
  typedef struct {logic [5:0] p; int c; int lat;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, ndone = 0, busy_cnt = 0;
  logic [5:0] last_p = 0;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  seq_mult_ctrl #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .P(P)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, expv, cyc);
    end
  endtask
  function automatic int lat(input logic [2:0] a, input logic [2:0] b);
    return (BYP == 1 && (a == 0 || b == 0)) ? 0 : 3;
  endfunction
  always @(negedge clk) begin
    if (rst) last_p = 0;
    else begin
      if (busy) busy_cnt++;
      if (done) begin
        exp_t e;
        ndone++;
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("product", 32'(P), 32'(e.p));
          chk("done_latency", cyc - e.c, e.lat);
          last_p = e.p;
        end
      end else chk("p_hold", 32'(P), 32'(last_p));
    end
  end
  task automatic op(input logic [2:0] a, input logic [2:0] b, input logic [5:0] p,
                    input bit keep, input bit push);
    int n = 0;
    start = 1;
    A = a;
    B = b;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", n < 100, 1);
    @(posedge clk); #1;
    if (!keep) start = 0;
    if (push) sb.push_back('{p, cyc, lat(a, b)});
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", n < 100, 1);
  endtask
  initial begin
    int b0, d0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_p", 32'(P), 0);
    op(7, 7, 49, 0, 1);
    wait_idle();
    op(5, 3, 15, 1, 1);
    op(6, 2, 12, 0, 1);
    wait_idle();
    b0 = busy_cnt;
    op(0, 6, 0, 0, 1);
    wait_idle();
    chk("zero_no_busy", (busy_cnt - b0) == 0, BYP);
    d0 = ndone;
    op(3, 5, 15, 0, 1);
    start = 1;
    A = 1;
    B = 1;
    @(posedge clk); #1;
    start = 0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1 chk("single_done", ndone - d0, 1);
    d0 = ndone;
    op(7, 6, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_p", 32'(P), 0);
    repeat (5) @(posedge clk);
    #1 chk("abort_no_done", ndone - d0, 0);
    op(2, 3, 6, 0, 1);
    wait_idle();
    repeat (2) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
